// File: rtl/aura_pkg.sv
// aura_pkg: shared definitions for the OPM write queue.
//   OPM_ADDR_W / OPM_DATA_W : OPM register address and data widths
//   opm_state_e             : replay FSM states
//   opm_entry_t             : one queued register write {addr, data}
package aura_pkg;

  localparam int OPM_ADDR_W = 8;
  localparam int OPM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_GAP
  } opm_state_e;

  typedef struct packed {
    logic [OPM_ADDR_W-1:0] addr;
    logic [OPM_DATA_W-1:0] data;
  } opm_entry_t;

endpackage

// File: rtl/opm_write_queue_if.sv
// opm_write_queue_if: CPU-side write port, OPM-side bus and queue status.
//   master : CPU decoder + OPM model (drives wr_*, flush, clr_ovf, opm_busy)
//   slave  : opm_write_queue (drives opm_* strobes/bus and status flags)
interface opm_write_queue_if #(
  parameter int DEPTH = 16
);
  import aura_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  // CPU side
  logic                  wr_en;
  logic                  wr_a0;
  logic [OPM_DATA_W-1:0] wr_data;
  logic                  flush;
  logic                  clr_ovf;
  // OPM side
  logic                  opm_cs_n;
  logic                  opm_wr_n;
  logic                  opm_a0;
  logic [OPM_DATA_W-1:0] opm_din;
  logic                  opm_busy;
  // status
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  queue_busy;
  logic                  overflow;

  modport master (
    output wr_en, wr_a0, wr_data, flush, clr_ovf, opm_busy,
    input  opm_cs_n, opm_wr_n, opm_a0, opm_din,
    input  fifo_count, fifo_full, queue_busy, overflow
  );

  modport slave (
    input  wr_en, wr_a0, wr_data, flush, clr_ovf, opm_busy,
    output opm_cs_n, opm_wr_n, opm_a0, opm_din,
    output fifo_count, fifo_full, queue_busy, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full/empty.
//   clk, resetn   : clock, asynchronous active-low reset
//   flush_i       : clear pointers and count (same-cycle push/pop ignored)
//   push_i/_data_i: write request; dropped when full (drop_o pulses)
//   pop_i         : read request; ignored when empty
//   pop_data_o    : head entry (valid while !empty_o)
//   count_o       : registered entry count; count_nxt_o is its next value
//   full_o/empty_o: registered flags
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_nxt_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Fullness is judged on the registered flag, so a push to a full FIFO is
  // dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_q & ~flush_i;
  assign pop_ok  = pop_i & ~empty_q & ~flush_i;
  assign drop_o  = push_i & full_q & ~flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: rtl/opm_write_queue.sv
// opm_write_queue: buffers CPU YM2151 register writes and replays them to the
// OPM with CS/WR pulse timing and busy-flag pacing.
//   clk, resetn : system clock, asynchronous active-low reset
//   bus (slave) : CPU write port (wr_en/wr_a0/wr_data/flush/clr_ovf),
//                 OPM bus (opm_cs_n/opm_wr_n/opm_a0/opm_din, opm_busy in),
//                 status (fifo_count/fifo_full/queue_busy/overflow)
module opm_write_queue
  import aura_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int MIN_GAP      = 8
) (
  input logic                clk,
  input logic                resetn,
  opm_write_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(MIN_GAP - 1);

  opm_state_e            state_q;
  opm_entry_t            entry_q;
  opm_entry_t            head;
  logic [OPM_ADDR_W-1:0] cpu_addr_q;
  logic [OPM_ADDR_W-1:0] last_addr_q;
  logic                  last_valid_q;
  logic [PW-1:0]         pulse_cnt_q;
  logic [GW-1:0]         gap_cnt_q;
  logic                  cs_n_q, wr_n_q, a0_q;
  logic [OPM_DATA_W-1:0] din_q;
  logic                  overflow_q;
  logic                  queue_busy_q;

  logic [$bits(opm_entry_t)-1:0] fifo_rdata;
  logic [CW-1:0]         fifo_count, fifo_count_nxt;
  logic                  fifo_full, fifo_empty, fifo_drop;
  logic                  push, pop_go, gap_done, going_idle;

  assign push = bus.wr_en & bus.wr_a0;
  assign head = opm_entry_t'(fifo_rdata);
  // No pop during flush: the head entry is being discarded, not replayed.
  assign pop_go     = (state_q == ST_IDLE) & ~fifo_empty & ~bus.flush;
  assign gap_done   = (state_q == ST_GAP) & (gap_cnt_q == GAP_LAST) & ~bus.opm_busy;
  assign going_idle = ((state_q == ST_IDLE) & ~pop_go) | gap_done;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(opm_entry_t))
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (bus.flush),
    .push_i      (push),
    .push_data_i ({cpu_addr_q, bus.wr_data}),
    .pop_i       (pop_go),
    .pop_data_o  (fifo_rdata),
    .count_o     (fifo_count),
    .count_nxt_o (fifo_count_nxt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  // CPU address shadow, sticky overflow, and registered queue_busy built
  // from next-state values so it lines up with the FSM/FIFO registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_addr_q   <= '0;
      overflow_q   <= 1'b0;
      queue_busy_q <= 1'b0;
    end else begin
      if (bus.wr_en && !bus.wr_a0) cpu_addr_q <= bus.wr_data;
      if (fifo_drop)        overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
      queue_busy_q <= ~going_idle | (fifo_count_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      entry_q      <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      pulse_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      a0_q         <= 1'b0;
      din_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_go) begin
            entry_q <= head;
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b1;
            if (last_valid_q && head.addr == last_addr_q) begin
              state_q <= ST_D_SETUP;
              a0_q    <= 1'b1;
              din_q   <= head.data;
            end else begin
              state_q <= ST_A_SETUP;
              a0_q    <= 1'b0;
              din_q   <= head.addr;
            end
          end
        end
        ST_A_SETUP: begin
          state_q     <= ST_A_PULSE;
          wr_n_q      <= 1'b0;
          pulse_cnt_q <= '0;
        end
        ST_A_PULSE: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            state_q <= ST_A_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PW'(1);
          end
        end
        ST_A_HOLD: begin
          state_q      <= ST_D_SETUP;
          last_addr_q  <= entry_q.addr;
          last_valid_q <= 1'b1;
          a0_q         <= 1'b1;
          din_q        <= entry_q.data;
        end
        ST_D_SETUP: begin
          state_q     <= ST_D_PULSE;
          wr_n_q      <= 1'b0;
          pulse_cnt_q <= '0;
        end
        ST_D_PULSE: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            state_q <= ST_D_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + PW'(1);
          end
        end
        ST_D_HOLD: begin
          state_q   <= ST_GAP;
          cs_n_q    <= 1'b1;
          gap_cnt_q <= '0;
        end
        ST_GAP: begin
          // Counter saturates; exit also needs busy low, sampled every cycle.
          if (gap_done) begin
            state_q <= ST_IDLE;
          end else if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.opm_cs_n   = cs_n_q;
  assign bus.opm_wr_n   = wr_n_q;
  assign bus.opm_a0     = a0_q;
  assign bus.opm_din    = din_q;
  assign bus.fifo_count = fifo_count;
  assign bus.fifo_full  = fifo_full;
  assign bus.queue_busy = queue_busy_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_opm_write_queue.sv
// tb_opm_write_queue: directed self-checking bench for opm_write_queue.
module tb_opm_write_queue;
  import aura_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  opm_write_queue_if #(.DEPTH(16)) bus ();

  opm_write_queue #(
    .DEPTH        (16),
    .PULSE_CYCLES (4),
    .MIN_GAP      (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: logs every completed WR pulse and every CS falling edge.
  int   cyc = 0;
  logic prev_wr = 1'b1;
  logic prev_cs = 1'b1;
  int   run = 0;
  logic       rec_a0  [256];
  logic [7:0] rec_din [256];
  int         rec_len [256];
  int         n_rec = 0;
  int         cs_fall [256];
  int         n_cs = 0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !bus.opm_cs_n && n_cs < 256) begin
      cs_fall[n_cs] = cyc;
      n_cs++;
    end
    if (!bus.opm_wr_n) begin
      run++;
    end else if (!prev_wr && n_rec < 256) begin
      rec_a0[n_rec]  = bus.opm_a0;
      rec_din[n_rec] = bus.opm_din;
      rec_len[n_rec] = run;
      n_rec++;
      run = 0;
    end
    prev_wr = bus.opm_wr_n;
    prev_cs = bus.opm_cs_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic a0, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_a0   = a0;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_a0   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && bus.queue_busy; i++) tick();
    chk({tag, " idle"}, 32'(bus.queue_busy), 0);
  endtask

  task automatic chk_rec(input string tag, input int idx, input logic a0, input logic [7:0] d);
    if (idx < 256) chk(tag, 32'({rec_a0[idx], rec_din[idx]}), 32'({a0, d}));
    else           chk(tag, 32'hFFFF_FFFF, 32'({a0, d}));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, r1;
    bus.wr_en    = 1'b0;
    bus.wr_a0    = 1'b0;
    bus.wr_data  = '0;
    bus.flush    = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.opm_busy = 1'b0;

    // Reset values
    #23;
    chk("rst cs_n",   32'(bus.opm_cs_n),   1);
    chk("rst wr_n",   32'(bus.opm_wr_n),   1);
    chk("rst a0",     32'(bus.opm_a0),     0);
    chk("rst din",    32'(bus.opm_din),    0);
    chk("rst count",  32'(bus.fifo_count), 0);
    chk("rst full",   32'(bus.fifo_full),  0);
    chk("rst qbusy",  32'(bus.queue_busy), 0);
    chk("rst ovf",    32'(bus.overflow),   0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Test 1: single address + data write, cycle-exact phase checks
    r0 = n_rec;
    cpu_wr(1'b0, 8'h28);
    cpu_wr(1'b1, 8'h42);
    chk("t1 count after push", 32'(bus.fifo_count), 1);
    chk("t1 cs idle",          32'(bus.opm_cs_n),   1);
    tick();
    chk("t1 a_setup cs",   32'(bus.opm_cs_n), 0);
    chk("t1 a_setup a0",   32'(bus.opm_a0),   0);
    chk("t1 a_setup din",  32'(bus.opm_din),  'h28);
    chk("t1 a_setup wr_n", 32'(bus.opm_wr_n), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1 a_pulse wr_n", 32'(bus.opm_wr_n), 0);
    end
    tick();
    chk("t1 a_hold wr_n", 32'(bus.opm_wr_n), 1);
    chk("t1 a_hold cs",   32'(bus.opm_cs_n), 0);
    tick();
    chk("t1 d_setup a0",   32'(bus.opm_a0),   1);
    chk("t1 d_setup din",  32'(bus.opm_din),  'h42);
    chk("t1 d_setup wr_n", 32'(bus.opm_wr_n), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1 d_pulse wr_n", 32'(bus.opm_wr_n), 0);
    end
    tick();
    chk("t1 d_hold wr_n", 32'(bus.opm_wr_n), 1);
    tick();
    chk("t1 gap cs",    32'(bus.opm_cs_n),   1);
    chk("t1 gap qbusy", 32'(bus.queue_busy), 1);
    repeat (7) tick();
    chk("t1 gap end qbusy", 32'(bus.queue_busy), 1);
    tick();
    chk("t1 idle qbusy", 32'(bus.queue_busy), 0);
    chk("t1 nrec",   32'(n_rec - r0), 2);
    chk_rec("t1 rec0", r0,     1'b0, 8'h28);
    chk_rec("t1 rec1", r0 + 1, 1'b1, 8'h42);
    chk("t1 a len", 32'(rec_len[r0]),     4);
    chk("t1 d len", 32'(rec_len[r0 + 1]), 4);

    // Test 2: same-address entries skip the address phase
    r0 = n_rec;
    c0 = n_cs;
    cpu_wr(1'b0, 8'h40);
    cpu_wr(1'b1, 8'h02);
    cpu_wr(1'b1, 8'h05);
    cpu_wr(1'b1, 8'h07);
    wait_idle(200, "t2");
    chk("t2 nrec", 32'(n_rec - r0), 4);
    chk_rec("t2 rec0", r0,     1'b0, 8'h40);
    chk_rec("t2 rec1", r0 + 1, 1'b1, 8'h02);
    chk_rec("t2 rec2", r0 + 2, 1'b1, 8'h05);
    chk_rec("t2 rec3", r0 + 3, 1'b1, 8'h07);
    chk("t2 ncs", 32'(n_cs - c0), 3);
    chk("t2 spacing A+D", 32'(cs_fall[c0 + 1] - cs_fall[c0]),     21);
    chk("t2 spacing D",   32'(cs_fall[c0 + 2] - cs_fall[c0 + 1]), 15);

    // Test 3: overflow with busy stuck high, then drain in order
    r0 = n_rec;
    bus.opm_busy = 1'b1;
    cpu_wr(1'b0, 8'h10);
    cpu_wr(1'b1, 8'h7F);
    repeat (20) tick();
    chk("t3 stuck qbusy", 32'(bus.queue_busy), 1);
    chk("t3 primer count", 32'(bus.fifo_count), 0);
    for (int i = 0; i < 17; i++) cpu_wr(1'b1, 8'(128 + i));
    chk("t3 count sat", 32'(bus.fifo_count), 16);
    chk("t3 full",      32'(bus.fifo_full),  1);
    chk("t3 ovf set",   32'(bus.overflow),   1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t3 ovf clr", 32'(bus.overflow), 0);
    repeat (50) tick();
    chk("t3 still stuck qbusy", 32'(bus.queue_busy), 1);
    chk("t3 still stuck cs",    32'(bus.opm_cs_n),   1);
    chk("t3 still count",       32'(bus.fifo_count), 16);
    bus.opm_busy = 1'b0;
    wait_idle(600, "t3");
    chk("t3 nrec", 32'(n_rec - r0), 18);
    chk_rec("t3 primer a", r0,     1'b0, 8'h10);
    chk_rec("t3 primer d", r0 + 1, 1'b1, 8'h7F);
    for (int i = 0; i < 16; i++) chk_rec("t3 drain", r0 + 2 + i, 1'b1, 8'(128 + i));
    chk("t3 count empty", 32'(bus.fifo_count), 0);
    chk("t3 full clr",    32'(bus.fifo_full),  0);

    // Test 4: busy rising 3 cycles into GAP holds the next entry
    r0 = n_rec;
    c0 = n_cs;
    cpu_wr(1'b0, 8'h28);
    cpu_wr(1'b1, 8'h11);
    cpu_wr(1'b0, 8'h30);
    cpu_wr(1'b1, 8'h22);
    repeat (14) tick();
    bus.opm_busy = 1'b1;
    repeat (30) tick();
    chk("t4 held cs", 32'(bus.opm_cs_n), 1);
    bus.opm_busy = 1'b0;
    wait_idle(200, "t4");
    chk("t4 ncs", 32'(n_cs - c0), 2);
    chk("t4 spacing", 32'(cs_fall[c0 + 1] - cs_fall[c0]), 47);
    chk("t4 nrec", 32'(n_rec - r0), 4);
    chk_rec("t4 second A", r0 + 2, 1'b0, 8'h30);

    // Test 5: flush during the first data pulse
    r0 = n_rec;
    c0 = n_cs;
    cpu_wr(1'b0, 8'h50);
    for (int i = 0; i < 5; i++) cpu_wr(1'b1, 8'(160 + i));
    chk("t5 count", 32'(bus.fifo_count), 4);
    repeat (4) tick();
    chk("t5 in d_pulse wr_n", 32'(bus.opm_wr_n), 0);
    chk("t5 in d_pulse a0",   32'(bus.opm_a0),   1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5 flushed count", 32'(bus.fifo_count), 0);
    chk("t5 pulse continues", 32'(bus.opm_wr_n), 0);
    wait_idle(100, "t5");
    chk("t5 nrec", 32'(n_rec - r0), 2);
    chk_rec("t5 rec0", r0,     1'b0, 8'h50);
    chk_rec("t5 rec1", r0 + 1, 1'b1, 8'hA0);
    chk("t5 d len", 32'(rec_len[r0 + 1]), 4);
    chk("t5 ncs", 32'(n_cs - c0), 1);
    chk("t5 ovf", 32'(bus.overflow), 0);

    // Test 6: asynchronous reset during the address pulse
    cpu_wr(1'b0, 8'h60);
    cpu_wr(1'b1, 8'h01);
    wait_idle(100, "t6 setup");
    cpu_wr(1'b0, 8'h61);
    cpu_wr(1'b1, 8'h03);
    tick();
    tick();
    chk("t6 in a_pulse", 32'(bus.opm_wr_n), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6 async wr_n", 32'(bus.opm_wr_n),   1);
    chk("t6 async cs_n", 32'(bus.opm_cs_n),   1);
    chk("t6 async count", 32'(bus.fifo_count), 0);
    chk("t6 async qbusy", 32'(bus.queue_busy), 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    r1 = n_rec;
    cpu_wr(1'b0, 8'h60);
    cpu_wr(1'b1, 8'h04);
    wait_idle(100, "t6");
    chk("t6 nrec", 32'(n_rec - r1), 2);
    chk_rec("t6 A after reset", r1,     1'b0, 8'h60);
    chk_rec("t6 D after reset", r1 + 1, 1'b1, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
